bus_byte_receiver: RTL and testbench
====================================

// Module: bus_byte_receiver
// PURPOSE
//  Receiving end of the IfcPkg byte bus. Accepts a valid/ready stream of byte_t
//  bytes with an end-of-frame flag and packs them into BYTES_PER_WORD-byte words.
//  Packed words go into a small output FIFO for the downstream word consumer.
//  A partial final word is closed with a byte-keep mask.
// PARAMETERS
//  BYTES_PER_WORD  4  bytes packed per output word; >=1
//  FIFO_DEPTH      4  output word FIFO entries; power of two, >=2
// PORTS
//  clk        in   1        clock; all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        input byte valid
//  in_ready   out  1        receiver can accept a byte
//  in_data    in   8        byte_t payload (IfcPkg::byte_t, WIDTH=8)
//  in_last    in   1        byte is last of frame
//  out_valid  out  1        FIFO head word valid
//  out_ready  in   1        consumer accepts head word
//  out_data   out  8*BPW    packed word; byte k at [8k+:8] (first byte = lane 0)
//  out_keep   out  BPW      valid-lane mask, contiguous from bit 0
//  out_last   out  1        word closed by in_last
//  byte_count out  16       total bytes accepted since reset
// BEHAVIOUR
//  - Handshakes:
//    - Byte accepted when in_valid && in_ready.
//    - Word popped when out_valid && out_ready.
//  - in_ready = (fifo_count < FIFO_DEPTH), taken from registered count only.
//    No combinational path from out_ready.
//  - Lane FSM:
//    - IDLE: lane=0, nothing held.
//    - FILL: 1..BPW-1 bytes held.
//    - IDLE->FILL on an accepted byte that neither fills the word nor has in_last.
//    - FILL->FILL on an accepted byte that does not close the word.
//    - ->IDLE when the word closes.
//  - Word closes when lane BPW-1 is written or in_last is accepted.
//    - Closed word is pushed to the FIFO at that same edge.
//    - out_valid rises 1 cycle after the closing byte is accepted (latency 1).
//  - Lanes not written in a closed word read as 0x00; their keep bits are 0.
//  - out_last=1 only for a word closed by in_last. A full word with in_last
//    on lane BPW-1 gives keep all-ones and last=1.
//  - BPW=1: every byte forms its own word, keep=1.
//  - FIFO:
//    - Read/write pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
//    - Push and pop in the same cycle: count unchanged, order preserved.
//    - Full: in_ready=0, so no push can occur. A pop frees a slot and
//      in_ready=1 on the next cycle.
//    - Empty: out_valid=0; out_data, out_keep and out_last drive 0.
//  - byte_count increments on each accepted byte. 16-bit, wraps 0xFFFF->0x0000.
//  - Reset:
//    - While rst=1: in_ready=0, out_valid=0, out_data/keep/last=0, byte_count=0.
//    - FSM goes to IDLE; FIFO and any partial word are discarded.
//    - in_ready=1 on the first cycle after rst falls.
//  - Reset mid-word or mid-frame: the partial word is lost, no word is emitted,
//    and the next byte lands in lane 0.
//  - in_data and in_last are ignored when in_valid=0 or in_ready=0.
// TESTING
//  T1 (BPW=4, out_ready=1): bytes 11,22,33,44, last on 44 -> 1 cycle later
//     out_data=0x44332211, keep=4'hF, last=1; byte_count=4.
//  T2: bytes AA,BB, last on BB -> out_data=0x0000BBAA, keep=4'h3, last=1;
//     FSM back in IDLE.
//  T3: out_ready=0, stream 16 bytes 00..0F -> 4 words; in_ready=0 after 16th byte.
//     Then out_ready=1 -> words 0x03020100..0x0F0E0D0C in order, all last=0;
//     in_ready=1 the cycle after the first pop.
//  T4: FIFO holds 1 word; pop and push on the same edge -> count stays 1,
//     out_valid held high, next word correct.
//  T5: 2 bytes accepted, rst pulsed 1 cycle -> no word emitted, byte_count=0.
//     Next frame 55,66,77,88 -> 0x88776655, byte 55 in lane 0.
//  T6: stream 65537 bytes -> byte_count=0x0001 (wrap); no words lost or reordered.

Source files
------------

// File: rtl/bus_byte_receiver_if.sv
// Byte-in / word-out bus bundle for bus_byte_receiver.
// The master side feeds bytes and consumes words; the slave side is the receiver.
interface bus_byte_receiver_if #(
    parameter int unsigned BYTES_PER_WORD = 4
);
    localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;

    logic                      in_valid;
    logic                      in_ready;
    logic [7:0]                in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [WORD_W-1:0]         out_data;
    logic [BYTES_PER_WORD-1:0] out_keep;
    logic                      out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/bus_byte_receiver.sv
// Packs a valid/ready byte stream into BYTES_PER_WORD-byte words with keep/last,
// buffered in a small word FIFO for the downstream consumer.
module bus_byte_receiver #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_byte_receiver_if.slave   bus,
    output logic [15:0]          byte_count
);
    localparam int unsigned BPW    = BYTES_PER_WORD;
    localparam int unsigned WORD_W = 8 * BPW;
    localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WORD_W-1:0] word_q, word_d, word_c;
    logic [BPW-1:0]    keep_q, keep_d, keep_c;
    logic              close_c;
    logic              accept_c;

    logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
    logic [BPW-1:0]    mem_keep [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q;
    logic [15:0]       byte_count_q;
    logic              out_valid_c;
    logic              pop_c;

    assign accept_c    = bus.in_valid && in_ready_q;
    assign out_valid_c = (count_q != '0);
    assign pop_c       = out_valid_c && bus.out_ready;

    // Lane FSM: merge the incoming byte into the partial word and decide closure
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        keep_d  = keep_q;
        close_c = 1'b0;
        word_c  = word_q;
        keep_c  = keep_q;
        word_c[int'(lane_q) * 8 +: 8] = bus.in_data;
        keep_c[lane_q]                = 1'b1;
        case (state_q)
            IDLE, FILL: begin
                if (accept_c) begin
                    if ((lane_q == LANE_W'(BPW - 1)) || bus.in_last) begin
                        close_c = 1'b1;
                        state_d = IDLE;
                        lane_d  = '0;
                        word_d  = '0;
                        keep_d  = '0;
                    end else begin
                        state_d = FILL;
                        lane_d  = lane_q + LANE_W'(1);
                        word_d  = word_c;
                        keep_d  = keep_c;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
                word_d  = '0;
                keep_d  = '0;
            end
        endcase
    end

    assign count_d = count_q + CNT_W'(close_c) - CNT_W'(pop_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            word_q       <= '0;
            keep_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            in_ready_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            keep_q     <= keep_d;
            count_q    <= count_d;
            in_ready_q <= (count_d < CNT_W'(FIFO_DEPTH));
            if (close_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (accept_c) begin
                byte_count_q <= byte_count_q + 16'd1;
            end
        end
    end

    // Storage needs no reset: pointers and count define what is live
    always_ff @(posedge clk) begin
        if (close_c) begin
            mem_data[wr_ptr_q] <= word_c;
            mem_keep[wr_ptr_q] <= keep_c;
            mem_last[wr_ptr_q] <= bus.in_last;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_valid_c ? mem_data[rd_ptr_q] : '0;
    assign bus.out_keep  = out_valid_c ? mem_keep[rd_ptr_q] : '0;
    assign bus.out_last  = out_valid_c ? mem_last[rd_ptr_q] : 1'b0;
    assign byte_count    = byte_count_q;
endmodule

// File: tb/tb_bus_byte_receiver.sv
// Directed bench for bus_byte_receiver: expected words are queued at stimulus time
// and a negedge monitor compares every word popped from the DUT.
module tb_bus_byte_receiver;
    localparam int unsigned BPW   = 4;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] byte_count;

    bus_byte_receiver_if #(.BYTES_PER_WORD(BPW)) bus ();

    bus_byte_receiver #(.BYTES_PER_WORD(BPW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    word_t exp_q[$];
    word_t mon_e;
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Scoreboard monitor: a word is consumed when valid and ready are both high
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got data 0x%0h keep 0x%0h last %0b, expected none",
                         bus.out_data, bus.out_keep, bus.out_last);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_data", 64'(bus.out_data), 64'(mon_e.data));
                check("word_keep", 64'(bus.out_keep), 64'(mon_e.keep));
                check("word_last", 64'(bus.out_last), 64'(mon_e.last));
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n++;
                if (n > 200) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout: in_ready=%0b, expected 1 within 200 cycles", bus.in_ready);
                    done = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",   64'(bus.in_ready),  64'd0);
        check("rst_out_valid",  64'(bus.out_valid), 64'd0);
        check("rst_out_data",   64'(bus.out_data),  64'd0);
        check("rst_out_keep",   64'(bus.out_keep),  64'd0);
        check("rst_out_last",   64'(bus.out_last),  64'd0);
        check("rst_byte_count", 64'(byte_count),    64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_ready", 64'(bus.in_ready), 64'd1);

        // T1: full word closed by last on lane 3
        push_exp(32'h44332211, 4'hF, 1'b1);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check("t1_no_early_valid", 64'(bus.out_valid), 64'd0);
        send_byte(8'h44, 1'b1);
        check("t1_latency_valid", 64'(bus.out_valid), 64'd1);
        check("t1_byte_count", 64'(byte_count), 64'd4);
        drain();

        // T2: short frame
        push_exp(32'h0000BBAA, 4'h3, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        check("t2_valid", 64'(bus.out_valid), 64'd1);
        check("t2_state_idle", 64'(dut.state_q), 64'd0);
        check("t2_lane_zero", 64'(dut.lane_q), 64'd0);
        drain();
        check("t2_byte_count", 64'(byte_count), 64'd6);

        // T3: fill the FIFO with out_ready low, then drain in order
        bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            push_exp({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)}, 4'hF, 1'b0);
        end
        for (int b = 0; b < 16; b++) begin
            send_byte(8'(b), 1'b0);
        end
        check("t3_full_not_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("t3_full_hold", 64'(bus.in_ready), 64'd0);
        check("t3_full_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_ready_after_pop", 64'(bus.in_ready), 64'd1);
        drain();
        check("t3_byte_count", 64'(byte_count), 64'd22);

        // T4: simultaneous push and pop with one word resident
        bus.out_ready = 1'b0;
        push_exp(32'hD4C3B2A1, 4'hF, 1'b0);
        push_exp(32'h04030201, 4'hF, 1'b1);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hD4, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        check("t4_count_before", 64'(dut.count_q), 64'd1);
        bus.out_ready = 1'b1;
        send_byte(8'h04, 1'b1);
        check("t4_count_same", 64'(dut.count_q), 64'd1);
        check("t4_valid_held", 64'(bus.out_valid), 64'd1);
        check("t4_next_head", 64'(bus.out_data), 64'h04030201);
        drain();

        // T5: reset mid-word discards the partial word
        send_byte(8'h99, 1'b0);
        send_byte(8'h9A, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_count", 64'(byte_count), 64'd0);
        check("t5_rst_valid", 64'(bus.out_valid), 64'd0);
        check("t5_rst_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_release_ready", 64'(bus.in_ready), 64'd1);
        push_exp(32'h88776655, 4'hF, 1'b1);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b1);
        drain();
        check("t5_byte_count", 64'(byte_count), 64'd4);

        // T6: byte_count wrap over a long stream
        pulse_reset();
        for (int j = 0; j < 16384; j++) begin
            push_exp({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)}, 4'hF, 1'b0);
        end
        push_exp(32'h00000000, 4'h1, 1'b1);
        for (int i = 0; i < 65537; i++) begin
            send_byte(8'(i), (i == 65536));
        end
        drain();
        check("t6_byte_count_wrap", 64'(byte_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
